// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;
    localparam logic [DIV_WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Magnitude of a two's complement value, widened by one bit so that
    // |INT_MIN| is representable.
    function automatic logic [DIV_WIDTH:0] abs_ext(input logic [DIV_WIDTH-1:0] v);
        logic [DIV_WIDTH:0] ext;
        ext = {v[DIV_WIDTH-1], v};
        return v[DIV_WIDTH-1] ? -ext : ext;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift/trial-subtract step of the divider (combinational).
// Ports:
//   rem_in   - partial remainder, WIDTH+1 bits
//   quo_in   - dividend/quotient shift register, WIDTH bits
//   divisor  - divisor magnitude, WIDTH+1 bits
//   rem_out  - next partial remainder
//   quo_out  - next quotient shift register (new quotient bit in the LSB)
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH:0]   divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    // Trial difference carries one extra bit so its sign is unambiguous.
    logic [WIDTH+1:0] trial;

    assign trial = {rem_in, quo_in[WIDTH-1]} - {1'b0, divisor};

    always_comb begin
        if (trial[WIDTH+1]) begin
            rem_out = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end else begin
            rem_out = trial[WIDTH:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Sequential signed 32-bit divider, restoring algorithm, one bit per cycle.
// Ports:
//   clock          - rising-edge clock
//   reset          - asynchronous active-low reset
//   ctrl_DIV       - start pulse; restarts any operation in flight
//   data_operandA  - dividend, sampled on the start edge
//   data_operandB  - divisor, sampled on the start edge
//   data_result    - quotient, held until the next completion
//   data_exception - divide-by-zero or INT_MIN/-1 overflow
//   data_resultRDY - one-cycle completion strobe
//
// state | meaning
// IDLE  | waiting for a start pulse
// RUN   | iterating steps (or one pass-through cycle for a special case)
// DONE  | result registered, ready strobe high this cycle
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    div_state_t           state, state_next;
    logic [DIV_CNT_W-1:0] cnt;
    logic [WIDTH:0]       rem, rem_next;
    logic [WIDTH-1:0]     quo, quo_next;
    logic [WIDTH:0]       div_mag;
    logic                 neg;
    logic                 div_zero;
    logic                 ovf;
    logic                 do_load, do_step, do_finish;
    logic                 last_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (div_mag),
        .rem_out (rem_next),
        .quo_out (quo_next)
    );

    assign last_step = div_zero || ovf || (cnt == DIV_CNT_W'(WIDTH));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // A start always wins the next state, but the edge that completes an
    // operation still publishes its result even if a new start lands on it.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_step    = 1'b0;
        do_finish  = 1'b0;
        case (state)
            IDLE: ;
            RUN: begin
                if (last_step) begin
                    do_finish  = 1'b1;
                    state_next = DONE;
                end else if (!ctrl_DIV) begin
                    do_step = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (ctrl_DIV) begin
            do_load    = 1'b1;
            state_next = RUN;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt            <= '0;
            rem            <= '0;
            quo            <= '0;
            div_mag        <= '0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            ovf            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= do_finish;
            if (do_finish) begin
                if (div_zero) begin
                    data_result    <= '0;
                    data_exception <= 1'b1;
                end else if (ovf) begin
                    data_result    <= INT_MIN;
                    data_exception <= 1'b1;
                end else begin
                    data_result    <= neg ? -quo : quo;
                    data_exception <= 1'b0;
                end
            end
            if (do_load) begin
                cnt      <= '0;
                rem      <= '0;
                // 32-bit negation of INT_MIN yields 0x80000000, which is the
                // correct unsigned magnitude 2^31.
                quo      <= data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
                div_mag  <= abs_ext(data_operandB);
                neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_zero <= (data_operandB == '0);
                ovf      <= (data_operandA == INT_MIN) && (data_operandB == '1);
            end else if (do_step) begin
                cnt <= cnt + DIV_CNT_W'(1);
                rem <= rem_next;
                quo <= quo_next;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int failures = 0;

    div_unit dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    // Reference: plain signed division (truncating) plus the two special cases.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic e);
        if (b == 32'd0) begin
            q = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = 32'($signed(a) / $signed(b));
            e = 1'b0;
        end
    endfunction

    function automatic int model_latency(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    // Pulse ctrl_DIV for one edge (E0); returns just after E0 with operands scrambled.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Starts an operation and observes 40 edges: first strobe edge, its
    // result/exception, and the total number of strobe cycles.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int rdy_edge, output logic [31:0] res,
                          output logic exc, output int strobes);
        start(a, b);
        rdy_edge = -1;
        strobes  = 0;
        res      = 'x;
        exc      = 1'bx;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                strobes++;
                if (rdy_edge < 0) begin
                    rdy_edge = e;
                    res      = data_result;
                    exc      = data_exception;
                end
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (data_result !== 32'd0) begin
            failures++;
            $display("FAIL reset_result got=%h exp=%h", data_result, 32'd0);
        end
        checks++;
        if (data_exception !== 1'b0) begin
            failures++;
            $display("FAIL reset_exception got=%b exp=0", data_exception);
        end
        checks++;
        if (data_resultRDY !== 1'b0) begin
            failures++;
            $display("FAIL reset_rdy got=%b exp=0", data_resultRDY);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] av[7] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C,
                               32'd7, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv[7] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'd0, 32'hFFFF_FFFF, 32'd1};
        logic [31:0] qv[7] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14,
                               32'd0, 32'h8000_0000, 32'h8000_0000};
        logic        ev[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int          lv[7] = '{33, 33, 33, 33, 1, 1, 33};
        int          edge_seen, strobes;
        logic [31:0] res;
        logic        exc;
        for (int i = 0; i < 7; i++) begin
            run_op(av[i], bv[i], edge_seen, res, exc, strobes);
            checks++;
            if (edge_seen !== lv[i] || strobes !== 1) begin
                failures++;
                $display("FAIL directed%0d_timing got edge=%0d strobes=%0d exp edge=%0d strobes=1",
                         i, edge_seen, strobes, lv[i]);
            end
            checks++;
            if (res !== qv[i] || exc !== ev[i]) begin
                failures++;
                $display("FAIL directed%0d_value got q=%h e=%b exp q=%h e=%b",
                         i, res, exc, qv[i], ev[i]);
            end
        end
    endtask

    task automatic test_random();
        int          edge_seen, strobes, lat;
        logic [31:0] a, b, q, res;
        logic        e, exc;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 100));
                2:       b = -32'($urandom_range(1, 100));
                3:       begin a = 32'h8000_0000; b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom; end
                4:       b = 32'hFFFF_FFFF;
                default: b = $urandom >> $urandom_range(0, 30);
            endcase
            model(a, b, q, e);
            lat = model_latency(a, b);
            run_op(a, b, edge_seen, res, exc, strobes);
            checks++;
            if (edge_seen !== lat || strobes !== 1) begin
                failures++;
                $display("FAIL random%0d_timing a=%h b=%h got edge=%0d strobes=%0d exp edge=%0d",
                         i, a, b, edge_seen, strobes, lat);
            end
            checks++;
            if (res !== q || exc !== e) begin
                failures++;
                $display("FAIL random%0d_value a=%h b=%h got q=%h e=%b exp q=%h e=%b",
                         i, a, b, res, exc, q, e);
            end
        end
    endtask

    task automatic test_restart();
        int          edge_seen, strobes, early;
        logic [31:0] res;
        logic        exc;
        early = 0;
        start(32'd1000, 32'd3);
        for (int e = 1; e <= 9; e++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) early++;
        end
        run_op(32'd50, 32'd5, edge_seen, res, exc, strobes);
        checks++;
        if (early !== 0 || edge_seen !== 33 || strobes !== 1) begin
            failures++;
            $display("FAIL restart_timing got early=%0d edge=%0d strobes=%0d exp early=0 edge=33 strobes=1",
                     early, edge_seen, strobes);
        end
        checks++;
        if (res !== 32'd10 || exc !== 1'b0) begin
            failures++;
            $display("FAIL restart_value got q=%h e=%b exp q=%h e=0", res, exc, 32'd10);
        end
    endtask

    task automatic test_reset_mid();
        int          edge_seen, strobes, stale;
        logic [31:0] res;
        logic        exc;
        stale = 0;
        start(32'd100, 32'd7);
        for (int e = 1; e <= 14; e++) begin
            @(posedge clock);
            #1;
        end
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_outputs got q=%h e=%b rdy=%b exp all zero",
                     data_result, data_exception, data_resultRDY);
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int e = 0; e < 40; e++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) stale++;
        end
        checks++;
        if (stale !== 0) begin
            failures++;
            $display("FAIL reset_mid_stale got strobes=%0d exp 0", stale);
        end
        run_op(32'd9, 32'd3, edge_seen, res, exc, strobes);
        checks++;
        if (edge_seen !== 33 || strobes !== 1 || res !== 32'd3 || exc !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_after got edge=%0d strobes=%0d q=%h e=%b exp edge=33 strobes=1 q=3 e=0",
                     edge_seen, strobes, res, exc);
        end
    endtask

    task automatic test_back_to_back();
        int          edge_seen, strobes, early;
        logic [31:0] q1, q2, res;
        logic        e1, e2, exc;
        model(32'hFFFF_FC18, 32'd7, q1, e1);
        model(32'd77, 32'hFFFF_FFF9, q2, e2);
        early = 0;
        start(32'hFFFF_FC18, 32'd7);
        for (int e = 1; e <= 32; e++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) early++;
        end
        start(32'd77, 32'hFFFF_FFF9);
        checks++;
        if (early !== 0 || data_resultRDY !== 1'b1 || data_result !== q1 || data_exception !== e1) begin
            failures++;
            $display("FAIL b2b_first got early=%0d rdy=%b q=%h e=%b exp early=0 rdy=1 q=%h e=%b",
                     early, data_resultRDY, data_result, data_exception, q1, e1);
        end
        edge_seen = -1;
        strobes   = 0;
        res       = 'x;
        exc       = 1'bx;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                strobes++;
                if (edge_seen < 0) begin
                    edge_seen = e;
                    res       = data_result;
                    exc       = data_exception;
                end
            end
        end
        checks++;
        if (edge_seen !== 33 || strobes !== 1 || res !== q2 || exc !== e2) begin
            failures++;
            $display("FAIL b2b_second got edge=%0d strobes=%0d q=%h e=%b exp edge=33 strobes=1 q=%h e=%b",
                     edge_seen, strobes, res, exc, q2, e2);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
